// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I/D main-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I and D cache miss paths.
import mem_arb_pkg::*;

module memory_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  I_READ,
    input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
    output logic [DATA_WIDTH-1:0] I_READDATA,
    output logic                  I_BUSYWAIT,
    input  logic                  D_READ,
    input  logic                  D_WRITE,
    input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
    input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
    output logic [DATA_WIDTH-1:0] D_READDATA,
    output logic                  D_BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
    output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [DATA_WIDTH-1:0] MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    arb_state_e            state_q, state_d;
    grant_e                grant_q, grant_d;
    grant_e                last_grant_q, last_grant_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  i_req;
    logic                  d_req;

    assign i_req = I_READ;
    assign d_req = D_READ | D_WRITE;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // On a tie the side not served last goes first.
                    if (i_req && d_req) begin
                        grant_d = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
                    end else begin
                        grant_d = d_req ? GRANT_D : GRANT_I;
                    end
                    if (grant_d == GRANT_D) begin
                        mem_write_d = D_WRITE;
                        mem_read_d  = ~D_WRITE;
                        mem_addr_d  = D_ADDRESS;
                        if (D_WRITE) begin
                            mem_wdata_d = D_WRITEDATA;
                        end
                    end else begin
                        mem_write_d = 1'b0;
                        mem_read_d  = 1'b1;
                        mem_addr_d  = I_ADDRESS;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!MEM_BUSYWAIT) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_read_q) begin
                        if (grant_q == GRANT_D) begin
                            d_rdata_d = MEM_READDATA;
                        end else begin
                            i_rdata_d = MEM_READDATA;
                        end
                    end
                    last_grant_d = grant_q;
                    state_d      = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_I;
            last_grant_q <= GRANT_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;
    assign I_READDATA    = i_rdata_q;
    assign D_READDATA    = d_rdata_q;

    // Stall is released only in the granted side's response cycle.
    assign I_BUSYWAIT = RESET & i_req &
                        ~((state_q == RESP) && (grant_q == GRANT_I));
    assign D_BUSYWAIT = RESET & d_req &
                        ~((state_q == RESP) && (grant_q == GRANT_D));

endmodule
